// File: rtl/connector_pkg.sv
// Shared defaults and width helpers for the channel aggregator.
package connector_pkg;

  localparam int NCH_DEF   = 3;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/connector_chan_fifo.sv
// Per-channel synchronous FIFO; a push while full is taken when a pop
// happens in the same cycle.
module connector_chan_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          data_i,
  output logic [DW-1:0]          data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/connector_chan_agg.sv
// Merges NCH write-enable channels through per-channel FIFOs onto one
// tagged valid/ready stream with round-robin arbitration.
module connector_chan_agg
  import connector_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             freeze,
  input  logic [NCH-1:0]                   wen,
  input  logic [NCH*DW-1:0]                data,
  input  logic                             ovf_clr,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [DW-1:0]                    o_data,
  output logic [clog2_min1(NCH)-1:0]       o_chan,
  output logic [NCH-1:0]                   ovf,
  output logic [NCH*($clog2(DEPTH)+1)-1:0] level
);

  localparam int CW = clog2_min1(NCH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NCH-1:0] empty, full, pop, push;
  logic [DW-1:0]  head [NCH];
  logic [LW-1:0]  lvl  [NCH];

  logic [CW-1:0]  rr_q, rr_d, gnt;
  logic [CW:0]    idx;
  logic           found, load_en, can_pop;

  logic           valid_q, valid_d;
  logic [DW-1:0]  data_q, data_d;
  logic [CW-1:0]  chan_q, chan_d;
  logic [NCH-1:0] ovf_q, ovf_d;

  assign push = wen & {NCH{~freeze}};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    connector_chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (push[i]),
      .pop_i  (pop[i]),
      .data_i (data[i*DW +: DW]),
      .data_o (head[i]),
      .full_o (full[i]),
      .empty_o(empty[i]),
      .level_o(lvl[i])
    );
    assign pop[i] = can_pop & (gnt == CW'(i));
    assign level[i*LW +: LW] = lvl[i];
  end

  // First non-empty channel at or after the rr pointer.
  always_comb begin
    gnt   = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, rr_q} + (CW+1)'(k);
      if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
      if (!found && !empty[idx[CW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[CW-1:0];
      end
    end
  end

  assign load_en = ~valid_q | o_ready;
  assign can_pop = load_en & ~freeze & found;

  always_comb begin
    rr_d    = rr_q;
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    if (can_pop) begin
      rr_d    = (gnt == CW'(NCH-1)) ? '0 : gnt + CW'(1);
      valid_d = 1'b1;
      data_d  = head[gnt];
      chan_d  = gnt;
    end else if (load_en) begin
      valid_d = 1'b0;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  assign ovf_d = (ovf_clr ? '0 : ovf_q) | (push & full & ~pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ovf_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_chan  = chan_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_connector_chan_agg.sv
// Directed scoreboard bench for connector_chan_agg (NCH=3, DW=8, DEPTH=4).
module tb_connector_chan_agg;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic [2:0]  wen;
  logic [23:0] data;
  logic        ovf_clr;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_data;
  logic [1:0]  o_chan;
  logic [2:0]  ovf;
  logic [8:0]  level;

  logic [9:0]  sb [$];
  logic [9:0]  exp_w;
  int          n_cmp = 0;
  int          n_err = 0;

  connector_chan_agg dut (
    .clk    (clk),
    .reset  (reset),
    .freeze (freeze),
    .wen    (wen),
    .data   (data),
    .ovf_clr(ovf_clr),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_chan (o_chan),
    .ovf    (ovf),
    .level  (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any handshake at the negedge, then advance past the next edge.
  task automatic tick();
    @(negedge clk);
    if (o_valid === 1'b1 && o_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $error("FAIL sb_unexpected observed=%0h expected=none",
               {o_chan, o_data});
      end else begin
        exp_w = sb.pop_front();
        assert ({o_chan, o_data} === exp_w) else begin
          n_err++;
          $error("FAIL sb_word observed=%0h expected=%0h",
                 {o_chan, o_data}, exp_w);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] w, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2);
    wen  = w;
    data = {d2, d1, d0};
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    freeze  = 1'b0;
    wen     = '0;
    data    = '0;
    ovf_clr = 1'b0;
    o_ready = 1'b1;
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_data",  o_data,  0);
    chk("rst_chan",  o_chan,  0);
    chk("rst_ovf",   ovf,     0);
    chk("rst_level", level,   0);
    tick();
    reset = 1'b0;

    // single word on channel 1
    drive(3'b010, 8'h00, 8'hA5, 8'h00);
    sb.push_back({2'd1, 8'hA5});
    tick();
    drive(3'b000, 8'h00, 8'h00, 8'h00);
    chk("t1_valid_n", o_valid, 0);
    tick();
    chk("t1_valid", o_valid, 1);
    chk("t1_data",  o_data,  8'hA5);
    chk("t1_chan",  o_chan,  1);
    tick();
    chk("t1_valid_low", o_valid, 0);
    chk("t1_sb", sb.size(), 0);

    // three-channel burst, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      drive(3'b111, 8'h11, 8'h22, 8'h33);
      sb.push_back({2'd0, 8'h11});
      sb.push_back({2'd1, 8'h22});
      sb.push_back({2'd2, 8'h33});
      tick();
      drive(3'b000, 8'h00, 8'h00, 8'h00);
      tick();
      chk("t2_first", {o_chan, o_data}, {2'd0, 8'h11});
      tick();
      chk("t2_second", {o_chan, o_data}, {2'd1, 8'h22});
      drain(6);
    end

    // overflow on channel 0 with output stalled
    o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(3'b001, 8'(8'h40 + k), 8'h00, 8'h00);
      if (k < 5) sb.push_back({2'd0, 8'(8'h40 + k)});
      tick();
      if (k >= 1) chk("t3_hold", {o_valid, o_data}, {1'b1, 8'h40});
    end
    drive(3'b000, 8'h00, 8'h00, 8'h00);
    chk("t3_ovf",   ovf,        3'b001);
    chk("t3_level", level[2:0], 3'd4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", ovf, 3'b000);

    // push into full FIFO while it pops
    o_ready = 1'b1;
    drive(3'b001, 8'h77, 8'h00, 8'h00);
    sb.push_back({2'd0, 8'h77});
    tick();
    drive(3'b000, 8'h00, 8'h00, 8'h00);
    chk("t5_level", level[2:0], 3'd4);
    chk("t5_ovf",   ovf,        3'b000);
    drain(12);

    // freeze with a pending output word
    o_ready = 1'b0;
    drive(3'b100, 8'h00, 8'h00, 8'h99);
    sb.push_back({2'd2, 8'h99});
    tick();
    drive(3'b100, 8'h00, 8'h00, 8'h9A);
    sb.push_back({2'd2, 8'h9A});
    tick();
    freeze = 1'b1;
    drive(3'b100, 8'h00, 8'h00, 8'hEE);
    tick();
    tick();
    drive(3'b000, 8'h00, 8'h00, 8'h00);
    chk("t4_level", level[8:6], 3'd1);
    chk("t4_ovf",   ovf,        3'b000);
    chk("t4_pend",  {o_valid, o_data}, {1'b1, 8'h99});
    o_ready = 1'b1;
    tick();
    chk("t4_drop_valid", o_valid, 0);
    tick();
    chk("t4_still_low", o_valid, 0);
    freeze = 1'b0;
    tick();
    chk("t4_resume", {o_valid, o_data}, {1'b1, 8'h9A});
    drain(6);

    // reset with words queued and output pending
    o_ready = 1'b0;
    drive(3'b111, 8'h01, 8'h02, 8'h03);
    tick();
    drive(3'b000, 8'h00, 8'h00, 8'h00);
    tick();
    chk("t6_pre_valid", o_valid, 1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t6_valid", o_valid, 0);
    chk("t6_level", level,   0);
    tick();
    reset   = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("t6_no_old", o_valid, 0);
    chk("t6_level_post", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
